// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware output FIFO for one router port.
// Buffers {header flag, byte} entries and tracks framing on the read side.
module router_pkt_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int LEN_LSB  = 2,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             hdr_out,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             pkt_done,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = WIDTH - LEN_LSB;
  localparam int RW = LW + 1;

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             hdr_q, hdr_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             clr, wa, ra;
  logic [WIDTH:0]   rd_entry;
  logic [LW-1:0]    rd_len;

  assign clr      = reset | soft_reset;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign wa       = write_enb & ~full & ~clr;
  assign ra       = read_enb & ~empty & ~clr;
  assign rd_entry = mem[rd_ptr_q];
  assign rd_len   = rd_entry[WIDTH-1:LEN_LSB];

  assign data_out = dout_q;
  assign hdr_out  = hdr_q;
  assign count    = count_q;
  assign pkt_done = done_q;
  assign err      = err_q;

  // Storage write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (wa) mem[wr_ptr_q] <= {lfd_state, data_in};
  end

  // Next-state for pointers, occupancy, read data and packet tracking.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rem_d    = rem_q;
    dout_d   = dout_q;
    hdr_d    = hdr_q;
    done_d   = 1'b0;
    err_d    = err_q;
    if (wa) wr_ptr_d = wr_ptr_q + AW'(1);
    case ({wa, ra})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (ra) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = rd_entry[WIDTH-1:0];
      hdr_d    = rd_entry[WIDTH];
      if (rd_entry[WIDTH]) begin
        // A header while bytes are still owed means the last packet was cut short.
        if (rem_q != '0) err_d = 1'b1;
        rem_d = RW'(rd_len) + RW'(1);
      end else if (rem_q != '0) begin
        rem_d  = rem_q - RW'(1);
        done_d = (rem_q == RW'(1));
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers; reset and soft_reset both flush everything.
  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      dout_q   <= '0;
      hdr_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      dout_q   <= dout_d;
      hdr_q    <= hdr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised, packet-aware successor to the router output FIFO. It sits between the router's FSM/register stage and each output port. It buffers WIDTH-bit bytes tagged with a first-byte (lfd_state) flag. It tracks packet boundaries on the read side from the header's length field, and reports occupancy, almost-full, packet completion and framing errors. It runs on one clock, with a synchronous active-high reset plus a synchronous soft_reset flush.

## Interface
- WIDTH, 8, data byte width (≥ LEN_LSB+1)
- DEPTH, 16, number of entries; power of 2, ≥ 4
- AF_LEVEL, DEPTH-2, count value at or above which almost_full asserts
- LEN_LSB, 2, payload length field is header[WIDTH-1:LEN_LSB]; header[LEN_LSB-1:0] is the address
- CW (local), $clog2(DEPTH)+1, count width

- clock  in  1  sole clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; highest priority
- soft_reset  in  1  synchronous flush; below reset, above read/write
- write_enb  in  1  write request
- read_enb  in  1  read request
- lfd_state  in  1  data_in is a packet header
- data_in  in  WIDTH  write data
- data_out  out  WIDTH  registered read data
- hdr_out  out  1  data_out is a header byte
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- count  out  CW  stored entries
- pkt_done  out  1  one-cycle pulse: data_out holds a packet's parity byte
- err  out  1  sticky framing error

## Operation
- Storage: DEPTH × (WIDTH+1) array, each entry is {lfd_state, data_in}. Pointers are wr_ptr and rd_ptr, each $clog2(DEPTH) bits. They wrap naturally from DEPTH-1 to 0.
- Accepted write: wa = write_enb & !full. Stores the entry at wr_ptr and increments wr_ptr.
- Accepted read: ra = read_enb & !empty. Loads data_out/hdr_out from rd_ptr and increments rd_ptr.
- Rejected requests (write while full, read while empty) change no state.
- Count update: +1 on wa only, −1 on ra only, unchanged when both occur.
- Simultaneous read and write:
  - When full: only the read is accepted, because the write is rejected.
  - When empty: only the write is accepted; data_out is not updated that cycle.
- Packet tracking uses a remaining counter, 1 + (WIDTH−LEN_LSB) bits wide, updated on each ra:
  - Header read: remaining ← header[WIDTH-1:LEN_LSB] + 1 (payload plus parity). A length of 0 gives remaining = 1.
  - Non-header read with remaining > 0: remaining decrements. If remaining was 1, this byte is the parity byte and pkt_done pulses.
- Framing error: err is set on ra when either of these occurs:
  - A header is read while remaining ≠ 0 (truncated packet). The new header is still loaded.
  - A non-header is read while remaining == 0 (orphan byte). The byte is still output.
- err clears only on reset or soft_reset.
- data_out and hdr_out hold their values when there is no ra.
- reset or soft_reset (identical effect):
  - Pointers, count, remaining, data_out, hdr_out, pkt_done and err go to 0.
  - empty goes to 1; full and almost_full go to 0.
  - Any read/write requested in the same cycle is ignored.
  - Memory contents need not be cleared.

## Timing
- Read latency is 1 cycle: ra at edge N gives data_out/hdr_out valid after edge N, and pkt_done is high for exactly that cycle.
- empty, full and almost_full are decoded combinationally from the count register, so they reflect an operation after the edge on which it is accepted.
- A write at edge N is readable with ra at edge N+1 at the earliest. There is no bypass.
- Reset values of all outputs: data_out 0, hdr_out 0, empty 1, full 0, almost_full 0 (given AF_LEVEL ≥ 1), count 0, pkt_done 0, err 0.
- A mid-packet soft_reset discards all stored bytes and the packet state. Bytes written in the following cycle are treated as a fresh stream.

## Test plan
- Reset with write_enb=read_enb=1 asserted → all outputs at their reset values; count stays 0.
- Write 16 bytes (DEPTH 16), then a 17th (0xAA):
  - full=1 and count=16 after the 16th write; the 17th is dropped.
  - almost_full rises when count reaches 14.
  - Reading 16 bytes returns them in order; empty=1 afterwards.
- Header 0x39 (length 14, address 01) + 14 payload bytes + parity, read back:
  - hdr_out=1 only on the first byte.
  - pkt_done pulses exactly once, with the parity byte; err=0.
- At full, hold read_enb=write_enb=1 for one cycle → count 15, the write is dropped. At count 8, the same → count stays 8 and the wrap-around order is preserved.
- Soft_reset after the header and 5 payload bytes are read → count 0, data_out 0. A new 0x05 (length 1) packet then reads cleanly with err=0.
- Header (length 3) read, then a second header read after only 1 payload byte → err=1, and it stays 1 until soft_reset.
